// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue sequencer: opcodes, FSM states and
// instruction field layout.
package alu_issue_pkg;

  localparam int INSTR_W = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  localparam int OP_LSB  = 13;
  localparam int OP_W    = 3;
  localparam int RD_LSB  = 10;
  localparam int RS1_LSB = 7;
  localparam int RS2_LSB = 4;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DECODE = 2'b01,
    EXEC   = 2'b10,
    WB     = 2'b11
  } state_t;

  function automatic logic [OP_W-1:0] instr_op(input logic [INSTR_W-1:0] ins);
    return ins[OP_LSB +: OP_W];
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Register file for the issue unit: three asynchronous read ports, one
// synchronous write port, entry 0 reads as zero and ignores writes.
module alu_issue_regfile
  import alu_issue_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int RIDX_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [RIDX_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [RIDX_W-1:0] i_rs1_addr,
  output logic [DATA_W-1:0] o_rs1_data,
  input  logic [RIDX_W-1:0] i_rs2_addr,
  output logic [DATA_W-1:0] o_rs2_data,
  input  logic [RIDX_W-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data
);

  logic [DATA_W-1:0] r_mem [NREGS];

  function automatic logic [DATA_W-1:0] rd_port(input logic [RIDX_W-1:0] addr,
                                                input logic [DATA_W-1:0] value);
    return (addr == {RIDX_W{1'b0}}) ? {DATA_W{1'b0}} : value;
  endfunction

  // Entry 0 is never written, so it simply keeps its reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
    end else if (i_wr_en && (i_wr_addr != {RIDX_W{1'b0}})) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end else begin
      r_mem <= r_mem;
    end
  end

  assign o_rs1_data = rd_port(i_rs1_addr, r_mem[i_rs1_addr]);
  assign o_rs2_data = rd_port(i_rs2_addr, r_mem[i_rs2_addr]);
  assign o_dbg_data = rd_port(i_dbg_addr, r_mem[i_dbg_addr]);

endmodule

// File: rtl/alu_issue_unit.sv
// Multi-cycle issue sequencer: accepts instruction words, reads operands,
// drives the external combinational ALU and writes results back.
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int NREGS  = 8,
  localparam int RIDX_W = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [2:0]         alu_ctrl,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               done,
  output logic               illegal,
  output logic               zero_flag,
  input  logic [RIDX_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  state_t               r_state;
  logic [INSTR_W-1:0]   r_instr;
  logic [DATA_W-1:0]    r_result;
  logic [DATA_W-1:0]    r_alu_a;
  logic [DATA_W-1:0]    r_alu_b;
  logic [2:0]           r_alu_ctrl;
  logic                 r_done;
  logic                 r_illegal;
  logic                 r_zero;

  logic [OP_W-1:0]      w_op;
  logic [RIDX_W-1:0]    w_rd;
  logic [RIDX_W-1:0]    w_rs1;
  logic [RIDX_W-1:0]    w_rs2;
  logic [DATA_W-1:0]    w_imm;
  logic [DATA_W-1:0]    w_rs1_data;
  logic [DATA_W-1:0]    w_rs2_data;
  logic                 w_wr_en;

  assign w_op    = instr_op(r_instr);
  assign w_rd    = r_instr[RD_LSB  +: RIDX_W];
  assign w_rs1   = r_instr[RS1_LSB +: RIDX_W];
  assign w_rs2   = r_instr[RS2_LSB +: RIDX_W];
  assign w_imm   = {{(DATA_W-IMM_W){1'b0}}, r_instr[IMM_LSB +: IMM_W]};
  assign w_wr_en = (r_state == WB);

  alu_issue_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .RIDX_W (RIDX_W)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_wr_en),
    .i_wr_addr  (w_rd),
    .i_wr_data  (r_result),
    .i_rs1_addr (w_rs1),
    .o_rs1_data (w_rs1_data),
    .i_rs2_addr (w_rs2),
    .o_rs2_data (w_rs2_data),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
  );

  // Sequencer FSM; reset also aborts any in-flight instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_instr    <= {INSTR_W{1'b0}};
      r_result   <= {DATA_W{1'b0}};
      r_alu_a    <= {DATA_W{1'b0}};
      r_alu_b    <= {DATA_W{1'b0}};
      r_alu_ctrl <= 3'b000;
      r_done     <= 1'b0;
      r_illegal  <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        IDLE: begin
          if (instr_valid) begin
            r_instr <= instr;
            r_state <= DECODE;
          end else begin
            r_state <= IDLE;
          end
        end
        DECODE: begin
          // LDI bypasses the ALU, so its operand registers keep their values.
          if (w_op == OP_LDI) begin
            r_result <= w_imm;
            r_state  <= WB;
          end else begin
            r_alu_a    <= w_rs1_data;
            r_alu_b    <= w_rs2_data;
            r_alu_ctrl <= w_op;
            if (w_op == OP_ILL) begin
              r_illegal <= 1'b1;
              r_state   <= IDLE;
            end else begin
              r_state <= EXEC;
            end
          end
        end
        EXEC: begin
          r_result <= alu_result;
          r_state  <= WB;
        end
        WB: begin
          r_zero  <= (r_result == {DATA_W{1'b0}});
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign instr_ready = (r_state == IDLE);
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_ctrl    = r_alu_ctrl;
  assign done        = r_done;
  assign illegal     = r_illegal;
  assign zero_flag   = r_zero;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit with an external ALU model and a
// register-file reference model driven by randomized instruction streams.
`timescale 1ns/1ps
module tb_alu_issue_unit;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [15:0] alu_result;
  logic        done;
  logic        illegal;
  logic        zero_flag;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] ref_rf [8];
  logic        ref_zero;

  alu_issue_unit #(.DATA_W(16), .NREGS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .done        (done),
    .illegal     (illegal),
    .zero_flag   (zero_flag),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational ALU that sits beside the unit.
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a ^ alu_b;
      3'b101:  alu_result = ~(alu_a | alu_b);
      default: alu_result = 16'h0000;
    endcase
  end

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 4'b0000};
  endfunction

  function automatic logic [15:0] enc_ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {3'b110, rd, 2'b00, imm};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) ref_rf[i] = 16'h0000;
    ref_zero = 1'b0;
  endtask

  task automatic model_exec(input logic [15:0] ins);
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    int          rd;
    op  = ins[15:13];
    rd  = int'(ins[12:10]);
    a   = ref_rf[ins[9:7]];
    b   = ref_rf[ins[6:4]];
    res = 16'h0000;
    case (op)
      3'b000: res = 16'((int'(a) + int'(b)) % 65536);
      3'b001: res = 16'((int'(a) - int'(b) + 65536) % 65536);
      3'b010: res = a & b;
      3'b011: res = a | b;
      3'b100: res = a ^ b;
      3'b101: res = 16'hFFFF ^ (a | b);
      3'b110: res = {8'h00, ins[7:0]};
      default: res = 16'h0000;
    endcase
    if (op != 3'b111) begin
      if (rd != 0) ref_rf[rd] = res;
      ref_zero = (res == 16'h0000);
    end
  endtask

  // Called at a negedge; returns at the negedge on which done/illegal is high.
  task automatic run_instr(input logic [15:0] ins);
    logic [2:0] op;
    logic [2:0] rd;
    int         exp_c;
    int         c;
    logic       saw_done;
    logic       saw_ill;
    op    = ins[15:13];
    rd    = ins[12:10];
    exp_c = (op == 3'b111) ? 2 : ((op == 3'b110) ? 3 : 4);
    instr = ins;
    instr_valid = 1'b1;
    c = 0;
    while (!instr_ready && c < 10) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (instr_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL accept_timeout: instr_ready=%b required 1", instr_ready);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_exec(ins);
    for (c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (done || illegal) break;
      instr = 16'($urandom);
    end
    saw_done = done;
    saw_ill  = illegal;
    instr_valid = 1'b0;
    n_checks++;
    if (c !== exp_c) begin
      n_errors++;
      $display("FAIL latency op=%b: got %0d cycles required %0d", op, c, exp_c);
    end
    n_checks++;
    if ({saw_done, saw_ill} !== ((op == 3'b111) ? 2'b01 : 2'b10)) begin
      n_errors++;
      $display("FAIL pulse_kind op=%b: done=%b illegal=%b", op, saw_done, saw_ill);
    end
    n_checks++;
    if (instr_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL ready_in_pulse: got %b required 1", instr_ready);
    end
    dbg_addr = rd;
    #1;
    n_checks++;
    if (dbg_data !== ref_rf[rd]) begin
      n_errors++;
      $display("FAIL rd_value r%0d: got %h required %h", rd, dbg_data, ref_rf[rd]);
    end
    n_checks++;
    if (zero_flag !== ref_zero) begin
      n_errors++;
      $display("FAIL zero_flag op=%b: got %b required %b", op, zero_flag, ref_zero);
    end
  endtask

  task automatic check_all_rf(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      n_checks++;
      if (dbg_data !== ref_rf[i]) begin
        n_errors++;
        $display("FAIL rf_%s r%0d: got %h required %h", tag, i, dbg_data, ref_rf[i]);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({instr_ready, done, illegal, zero_flag} !== 4'b1000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b required 1000", {instr_ready, done, illegal, zero_flag});
    end
    n_checks++;
    if ({alu_a, alu_b, alu_ctrl} !== 35'd0) begin
      n_errors++;
      $display("FAIL reset_alu_regs: got %h/%h/%b required 0", alu_a, alu_b, alu_ctrl);
    end
    rst = 1'b0;
    check_all_rf("reset");
    @(negedge clk);
  endtask

  task automatic test_ldi();
    run_instr(enc_ldi(3'd1, 8'h05));
    run_instr(enc_ldi(3'd2, 8'h03));
    dbg_addr = 3'd1;
    #1;
    n_checks++;
    if (dbg_data !== 16'h0005) begin
      n_errors++;
      $display("FAIL ldi_r1: got %h required 0005", dbg_data);
    end
    dbg_addr = 3'd2;
    #1;
    n_checks++;
    if (dbg_data !== 16'h0003) begin
      n_errors++;
      $display("FAIL ldi_r2: got %h required 0003", dbg_data);
    end
  endtask

  task automatic test_alu_ops();
    run_instr(enc(3'b000, 3'd3, 3'd1, 3'd2));
    run_instr(enc(3'b001, 3'd4, 3'd2, 3'd1));
    dbg_addr = 3'd4;
    #1;
    n_checks++;
    if (dbg_data !== 16'hFFFE) begin
      n_errors++;
      $display("FAIL sub_wrap: got %h required FFFE", dbg_data);
    end
    run_instr(enc(3'b100, 3'd5, 3'd1, 3'd1));
    n_checks++;
    if (zero_flag !== 1'b1) begin
      n_errors++;
      $display("FAIL xor_zero_flag: got %b required 1", zero_flag);
    end
    run_instr(enc(3'b101, 3'd6, 3'd0, 3'd0));
    dbg_addr = 3'd6;
    #1;
    n_checks++;
    if (dbg_data !== 16'hFFFF || zero_flag !== 1'b0) begin
      n_errors++;
      $display("FAIL nor_r0: got %h zf=%b required FFFF zf=0", dbg_data, zero_flag);
    end
    check_all_rf("alu");
  endtask

  task automatic test_illegal();
    run_instr(enc(3'b111, 3'd3, 3'd1, 3'd2));
    @(negedge clk);
    n_checks++;
    if ({done, illegal} !== 2'b00) begin
      n_errors++;
      $display("FAIL illegal_after: done=%b illegal=%b required 00", done, illegal);
    end
    check_all_rf("illegal");
  endtask

  task automatic test_r0_write();
    run_instr(enc(3'b100, 3'd5, 3'd2, 3'd2));
    run_instr(enc(3'b000, 3'd0, 3'd1, 3'd2));
    dbg_addr = 3'd0;
    #1;
    n_checks++;
    if (dbg_data !== 16'h0000 || zero_flag !== 1'b0) begin
      n_errors++;
      $display("FAIL r0_write: got %h zf=%b required 0000 zf=0", dbg_data, zero_flag);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ins;
    logic [2:0]  op;
    for (int k = 0; k < 60; k++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'b110) ins = enc_ldi(3'($urandom), 8'($urandom));
      else ins = enc(op, 3'($urandom), 3'($urandom), 3'($urandom));
      run_instr(ins);
    end
    check_all_rf("random");
  endtask

  task automatic test_reset_mid();
    int seen_done;
    run_instr(enc_ldi(3'd1, 8'h05));
    run_instr(enc(3'b100, 3'd5, 3'd1, 3'd1));
    instr = enc(3'b000, 3'd7, 3'd1, 3'd1);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_clear();
    n_checks++;
    if ({instr_ready, done, illegal, zero_flag} !== 4'b1000) begin
      n_errors++;
      $display("FAIL midreset_flags: got %b required 1000", {instr_ready, done, illegal, zero_flag});
    end
    n_checks++;
    if ({alu_a, alu_b, alu_ctrl} !== 35'd0) begin
      n_errors++;
      $display("FAIL midreset_alu_regs: got %h/%h/%b required 0", alu_a, alu_b, alu_ctrl);
    end
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || illegal) seen_done++;
    end
    n_checks++;
    if (seen_done !== 0) begin
      n_errors++;
      $display("FAIL midreset_pulse: got %0d pulses required 0", seen_done);
    end
    check_all_rf("midreset");
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 16'h0000;
    dbg_addr = 3'd0;
    model_clear();
    repeat (3) @(posedge clk);
    test_reset();
    test_ldi();
    test_alu_ops();
    test_illegal();
    test_r0_write();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
